// File: rtl/clk_rst_seq_pkg.sv
//------------------------------------------------------------------------------
// clk_rst_seq_pkg : shared types and constants for the clock/reset sequencer (rev 1.0)
//------------------------------------------------------------------------------
`default_nettype none

package clk_rst_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    STAGGER = 2'd2,
    RUN     = 2'd3
  } state_t;

  localparam int DIV_48M_TO_12M = 4;
  localparam int DIV_48M_TO_1M5 = 32;

  // Width needed to hold the release point of the last channel.
  function automatic int seq_cnt_w(input int dly, input int step, input int ch_num);
    int last;
    last = dly + (ch_num - 1) * step;
    return (last < 2) ? 1 : $clog2(last + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_rst_div_ch.sv
//------------------------------------------------------------------------------
// clk_rst_div_ch : one divider channel producing a tick enable and divided clock (rev 1.0)
//------------------------------------------------------------------------------
`default_nettype none

module clk_rst_div_ch #(
  parameter int P_CNT_W = 16
) (
  input  logic               clk,
  input  logic               rstl,
  input  logic               run,
  input  logic               sync,
  input  logic [P_CNT_W-1:0] div,
  output logic               tick,
  output logic               div_clk
);

  logic [P_CNT_W-1:0] div_q;
  logic [P_CNT_W-1:0] cnt;
  logic [P_CNT_W-1:0] d_m1;
  logic [P_CNT_W-1:0] half;
  logic               wrap;

  // A ratio of zero behaves as one: terminal count 0, clock held low.
  always_comb begin
    d_m1 = (div_q == '0) ? '0 : div_q - 1'b1;
    half = div_q >> 1;
    wrap = (cnt == d_m1);
  end

  always_ff @(posedge clk or negedge rstl) begin
    if (!rstl) begin
      cnt     <= '0;
      div_q   <= '0;
      tick    <= 1'b0;
      div_clk <= 1'b0;
    end else if (!run) begin
      cnt     <= '0;
      div_q   <= div;
      tick    <= 1'b0;
      div_clk <= 1'b0;
    end else begin
      tick    <= wrap && !sync;
      div_clk <= (cnt < half);
      if (sync || wrap) begin
        cnt   <= '0;
        div_q <= div;
      end else begin
        cnt   <= cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/clk_rst_seq.sv
//------------------------------------------------------------------------------
// clk_rst_seq : multi-channel clock-enable and staggered reset sequencer (rev 1.0)
//------------------------------------------------------------------------------
`default_nettype none

module clk_rst_seq
  import clk_rst_seq_pkg::*;
#(
  parameter int P_CH_NUM   = 4,
  parameter int P_CNT_W    = 16,
  parameter int P_RST_DLY  = 2500,
  parameter int P_RST_STEP = 16,
  parameter int P_EN_SYNC  = 2
) (
  input  logic                        clk,
  input  logic                        rstl,
  input  logic                        en,
  input  logic                        sync_i,
  input  logic [P_CH_NUM*P_CNT_W-1:0] div_i,
  output logic [P_CH_NUM-1:0]         tick_o,
  output logic [P_CH_NUM-1:0]         div_clk_o,
  output logic [P_CH_NUM-1:0]         rsth_o,
  output logic                        done_o
);

  localparam int               SEQ_W       = seq_cnt_w(P_RST_DLY, P_RST_STEP, P_CH_NUM);
  localparam logic [SEQ_W-1:0] DLY_C       = SEQ_W'(P_RST_DLY);
  localparam logic [SEQ_W-1:0] LAST_C      = SEQ_W'(P_RST_DLY + (P_CH_NUM - 1) * P_RST_STEP);
  localparam bit               ALL_AT_ONCE = (P_CH_NUM == 1) || (P_RST_STEP == 0);

  logic en_s;

  generate
    if (P_EN_SYNC == 0) begin : g_en_direct
      assign en_s = en;
    end else begin : g_en_sync
      logic [P_EN_SYNC-1:0] sync_q;
      always_ff @(posedge clk or negedge rstl) begin
        if (!rstl) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= en;
          for (int i = 1; i < P_EN_SYNC; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end
      assign en_s = sync_q[P_EN_SYNC-1];
    end
  endgenerate

  state_t             state;
  state_t             state_nxt;
  logic [SEQ_W-1:0]   seq;
  logic [SEQ_W-1:0]   seq_nxt;
  logic [P_CH_NUM-1:0] rsth_nxt;
  logic               run;

  always_comb begin
    state_nxt = state;
    seq_nxt   = seq;
    if (!en_s) begin
      state_nxt = IDLE;
      seq_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = HOLD;
          seq_nxt   = '0;
        end
        HOLD: begin
          seq_nxt = seq + 1'b1;
          if (seq_nxt == DLY_C) begin
            state_nxt = ALL_AT_ONCE ? RUN : STAGGER;
          end
        end
        STAGGER: begin
          seq_nxt = seq + 1'b1;
          if (seq_nxt == LAST_C) begin
            state_nxt = RUN;
          end
        end
        RUN: begin
          seq_nxt = seq;
        end
        default: begin
          state_nxt = IDLE;
          seq_nxt   = '0;
        end
      endcase
    end
  end

  // Channel k leaves reset once the sequence count reaches its release point.
  generate
    for (genvar k = 0; k < P_CH_NUM; k++) begin : g_rsth
      localparam logic [SEQ_W-1:0] THR = SEQ_W'(P_RST_DLY + k * P_RST_STEP);
      assign rsth_nxt[k] = (state_nxt == IDLE) || (seq_nxt < THR);
    end
  endgenerate

  always_ff @(posedge clk or negedge rstl) begin
    if (!rstl) begin
      state  <= IDLE;
      seq    <= '0;
      rsth_o <= '1;
      done_o <= 1'b0;
    end else begin
      state  <= state_nxt;
      seq    <= seq_nxt;
      rsth_o <= rsth_nxt;
      done_o <= (state_nxt == RUN);
    end
  end

  assign run = en_s && (state != IDLE);

  generate
    for (genvar k = 0; k < P_CH_NUM; k++) begin : g_ch
      clk_rst_div_ch #(
        .P_CNT_W (P_CNT_W)
      ) u_ch (
        .clk     (clk),
        .rstl    (rstl),
        .run     (run),
        .sync    (sync_i),
        .div     (div_i[k*P_CNT_W +: P_CNT_W]),
        .tick    (tick_o[k]),
        .div_clk (div_clk_o[k])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_clk_rst_seq.sv
//------------------------------------------------------------------------------
// tb_clk_rst_seq : directed self-checking bench for clk_rst_seq (rev 1.0)
//------------------------------------------------------------------------------
`default_nettype none

module tb_clk_rst_seq;

  localparam int CH = 3;
  localparam int CW = 16;

  // Observed vector layout: {rsth_o[2:0], done_o, tick_o[2:0], div_clk_o[2:0]}
  localparam logic [9:0] IDLE_V = {3'b111, 1'b0, 3'b000, 3'b000};

  logic              clk = 1'b0;
  logic              rstl;
  logic              en;
  logic              sync_i;
  logic [CH*CW-1:0]  div_i;
  logic [CH-1:0]     tick_o;
  logic [CH-1:0]     div_clk_o;
  logic [CH-1:0]     rsth_o;
  logic              done_o;
  logic [9:0]        obs_v;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign obs_v = {rsth_o, done_o, tick_o, div_clk_o};

  clk_rst_seq #(
    .P_CH_NUM   (CH),
    .P_CNT_W    (CW),
    .P_RST_DLY  (8),
    .P_RST_STEP (4),
    .P_EN_SYNC  (0)
  ) dut (
    .clk       (clk),
    .rstl      (rstl),
    .en        (en),
    .sync_i    (sync_i),
    .div_i     (div_i),
    .tick_o    (tick_o),
    .div_clk_o (div_clk_o),
    .rsth_o    (rsth_o),
    .done_o    (done_o)
  );

  // p = edges since a counter sat at 0 right after an edge.
  function automatic logic tk(input int p, input int d);
    return (p > 0) && (p % d == 0);
  endfunction

  function automatic logic dk(input int p, input int d);
    return (p > 0) && (p % d >= 1) && (p % d <= d / 2);
  endfunction

  // e = edges since HOLD entry, all counters aligned to that entry.
  function automatic logic [9:0] base_v(input int e, input int d0, input int d1, input int d2);
    return {(e < 16), (e < 12), (e < 8), (e >= 16),
            tk(e, d2), tk(e, d1), tk(e, d0),
            dk(e, d2), dk(e, d1), dk(e, d0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstl   = 1'b1;
    en     = 1'b0;
    sync_i = 1'b0;
    div_i  = {16'd1, 16'd5, 16'd4};
    #3 rstl = 1'b0;
    #1;
    n_checks++;
    if (obs_v !== IDLE_V) begin
      n_fail++;
      $display("FAIL reset_async got=%b exp=%b", obs_v, IDLE_V);
    end
    repeat (2) step();
    n_checks++;
    if (obs_v !== IDLE_V) begin
      n_fail++;
      $display("FAIL reset_held got=%b exp=%b", obs_v, IDLE_V);
    end
    rstl = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if (obs_v !== IDLE_V) begin
        n_fail++;
        $display("FAIL idle_en_low i=%0d got=%b exp=%b", i, obs_v, IDLE_V);
      end
      if (i == 2) sync_i = 1'b1;
      if (i == 3) sync_i = 1'b0;
    end
    en = 1'b1;
  endtask

  task automatic test_release();
    logic [9:0] exp_v;
    for (int e = 0; e <= 25; e++) begin
      step();
      exp_v = base_v(e, 4, 5, 1);
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL release e=%0d got=%b exp=%b", e, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_div_change();
    logic [9:0] exp_v;
    logic       c0t;
    logic       c0d;
    div_i[CW-1:0] = 16'd6;
    for (int e = 26; e <= 40; e++) begin
      step();
      c0t   = (e <= 28) ? tk(e, 4) : tk(e - 28, 6);
      c0d   = (e <= 28) ? dk(e, 4) : dk(e - 28, 6);
      exp_v = {3'b000, 1'b1, tk(e, 1), tk(e, 5), c0t, dk(e, 1), dk(e, 5), c0d};
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL div_change e=%0d got=%b exp=%b", e, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_sync();
    logic [9:0] exp_v;
    int p0;
    int p12;
    for (int e = 41; e <= 52; e++) begin
      step();
      p0    = (e < 45) ? e - 28 : e - 45;
      p12   = (e < 45) ? e : e - 45;
      exp_v = {3'b000, 1'b1, tk(p12, 1), tk(p12, 5), tk(p0, 6),
               dk(p12, 1), dk(p12, 5), dk(p0, 6)};
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL sync e=%0d got=%b exp=%b", e, obs_v, exp_v);
      end
      if (e == 44) sync_i = 1'b1;
      if (e == 45) sync_i = 1'b0;
    end
  endtask

  task automatic test_en_drop();
    logic [9:0] exp_v;
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (obs_v !== IDLE_V) begin
        n_fail++;
        $display("FAIL en_low_run i=%0d got=%b exp=%b", i, obs_v, IDLE_V);
      end
    end
    en = 1'b1;
    for (int r = 0; r <= 40; r++) begin
      step();
      if (r >= 15 && r < 20) exp_v = IDLE_V;
      else                   exp_v = base_v((r < 15) ? r : r - 20, 6, 5, 1);
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL en_restart r=%0d got=%b exp=%b", r, obs_v, exp_v);
      end
      if (r == 14) en = 1'b0;
      if (r == 16) sync_i = 1'b1;
      if (r == 17) sync_i = 1'b0;
      if (r == 19) en = 1'b1;
    end
  endtask

  task automatic test_async_reset();
    logic [9:0] exp_v;
    #2 rstl = 1'b0;
    #1;
    n_checks++;
    if (obs_v !== IDLE_V) begin
      n_fail++;
      $display("FAIL async_mid_run got=%b exp=%b", obs_v, IDLE_V);
    end
    step();
    n_checks++;
    if (obs_v !== IDLE_V) begin
      n_fail++;
      $display("FAIL async_held got=%b exp=%b", obs_v, IDLE_V);
    end
    rstl = 1'b1;
    en   = 1'b0;
    step();
    n_checks++;
    if (obs_v !== IDLE_V) begin
      n_fail++;
      $display("FAIL post_reset_idle got=%b exp=%b", obs_v, IDLE_V);
    end
    en = 1'b1;
    for (int r = 0; r <= 9; r++) begin
      step();
      exp_v = base_v(r, 6, 5, 1);
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL restart_after_rst r=%0d got=%b exp=%b", r, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_div_change();
    test_sync();
    test_en_drop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

`default_nettype wire
